stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (legal range 2..16, any value, not only powers of two).
REQ-002 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester ready; at most one bit set per cycle.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  payloads, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port out_valid  output  1  registered output stage holds a beat.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port out_data  output  WIDTH  registered payload of the held beat.
REQ-011 SHALL have port out_src  output  $clog2(NUM_REQ)  index of the requester that supplied the held beat.

Function
REQ-012 SHALL transfer on a port exactly when valid and ready are both high at a rising clk edge.
REQ-013 SHALL define slot_free = !out_valid || out_ready; a new beat is accepted only when slot_free is high.
REQ-014 SHALL, when slot_free is high and one or more req_valid bits are set, grant exactly one requester per the arbitration policy and drive only that requester's req_ready high, combinationally in the same cycle.
REQ-015 SHALL drive all req_ready bits low when slot_free is low or no req_valid bit is set.
REQ-016 SHALL, on a grant, load out_data with the granted payload, out_src with its index and set out_valid at the next edge: one-cycle latency.
REQ-017 SHALL, when slot_free is high and no requester is valid, clear out_valid at the next edge; out_data and out_src then hold their prior values.
REQ-018 SHALL hold out_valid, out_data and out_src stable while out_valid is high and out_ready is low.
REQ-019 SHALL sustain one beat per cycle when out_ready stays high and any requester is valid.
REQ-020 SHALL keep a round-robin pointer ptr (0..NUM_REQ-1): the grant goes to the first valid requester found scanning ptr, ptr+1, ... modulo NUM_REQ.
REQ-021 SHALL set ptr to (granted index + 1) modulo NUM_REQ after each grant, wrapping from NUM_REQ-1 to 0 and also for non-power-of-two NUM_REQ; ptr SHALL not change in cycles without a grant.
REQ-022 SHALL guarantee that a requester holding req_valid high is granted within NUM_REQ grants.
REQ-023 SHALL keep req_ready independent of out_data and out_src, and keep no combinational path from req_valid to out_valid.

Reset
REQ-024 SHALL, while rst is high at an edge, set out_valid=0, out_data=0, out_src=0 and ptr=0.
REQ-025 SHALL force all req_ready bits low in every cycle rst is high, regardless of req_valid.
REQ-026 SHALL discard a held beat when reset is asserted mid-operation, even if out_ready was low; no transfer is reported for that cycle.
REQ-027 SHALL restart arbitration from requester 0 in the first cycle after rst falls.

Configuration
REQ-028 SHALL honour the macro STREAM_ARB_FIXED_PRIO_EN; when it is defined, the arbitration policy is fixed priority (lowest valid index wins), ptr is not implemented and REQ-020..REQ-022 do not apply.
REQ-029 SHALL, when STREAM_ARB_FIXED_PRIO_EN is undefined, use the round-robin policy of REQ-020..REQ-022; ports and timing are identical in both builds.

Verification
REQ-030 SHALL cover: NUM_REQ=4; all four valid with data 0xA0..0xA3, out_ready=1 -> out_src sequence 0,1,2,3,0; one beat per cycle.
REQ-031 SHALL cover: only req 2 valid (0x55) with out_ready=0 for 3 cycles -> out_valid=1, out_data=0x55 and out_src=2 all stable; req_ready=0000 until out_ready=1.
REQ-032 SHALL cover: NUM_REQ=3; grant req 2 -> ptr wraps to 0; then reqs 0 and 1 both valid -> req 0 granted first.
REQ-033 SHALL cover: rst pulsed for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0 next cycle; next grant starts at req 0.
REQ-034 SHALL cover: STREAM_ARB_FIXED_PRIO_EN defined; reqs 1 and 3 continuously valid with out_ready=1 -> req 1 granted every cycle.
REQ-035 SHALL cover: idle cycle (no req_valid, out_ready=1) after a beat -> out_valid=0; out_data retains its last value.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: N-to-1 stream arbiter with a registered output stage.
//
// Handshake: on every port a beat moves exactly when valid and ready are both
// high at a rising clk edge. A source holds valid (and its data) until it sees
// ready. req_ready is one-hot or zero and is computed combinationally from
// req_valid, the round-robin pointer and the state of the output slot.
//
// Build option: define STREAM_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest valid index wins). The pointer register is then not
// built. Ports and timing are the same in both builds.
module stream_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(NUM_REQ)-1:0] out_src
);

   localparam int SRC_W = $clog2(NUM_REQ);

   logic             slot_free;
   logic             grant_found;
   logic [SRC_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;

   // The output slot can take a new beat when it is empty or being drained now.
   assign slot_free = !out_valid || out_ready;

`ifdef STREAM_ARB_FIXED_PRIO_EN
   // Fixed priority: scanning downward lets the lowest valid index win.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(i);
         end
      end
   end
`else
   logic [SRC_W-1:0] ptr;

   // Round-robin: the lowest valid index at or above ptr wins; if none, the
   // search wraps and the lowest valid index overall wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i >= int'(ptr))) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(i);
         end
      end
   end

   // Pointer moves to the slot after the winner, wrapping for any NUM_REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (slot_free && grant_found) begin
         if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= grant_idx + 1'b1;
         end
      end
   end
`endif

   // One-hot ready for the winner and payload mux; nothing is granted in reset.
   always_comb begin
      req_ready  = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (SRC_W'(i) == grant_idx) begin
            grant_data = req_data[i*WIDTH +: WIDTH];
            if (slot_free && grant_found && !rst) begin
               req_ready[i] = 1'b1;
            end
         end
      end
   end

   // Output stage: load on a grant, empty when free and idle, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (slot_free) begin
         out_valid <= grant_found;
         if (grant_found) begin
            out_data <= grant_data;
            out_src  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: a 4-requester instance driven from a vector
// table and by random traffic against a queue-free reference model, plus a
// 3-requester instance for the pointer wrap sequence.
module tb_stream_rr_arbiter;

   localparam int W = 8;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4 = 1'b1;
   logic [3:0]  v4   = '0;
   logic [3:0]  r4;
   logic [31:0] d4   = '0;
   logic        ov4;
   logic        or4  = 1'b0;
   logic [7:0]  od4;
   logic [1:0]  os4;

   logic        rst3 = 1'b1;
   logic [2:0]  v3   = '0;
   logic [2:0]  r3;
   logic [23:0] d3   = '0;
   logic        ov3;
   logic        or3  = 1'b0;
   logic [7:0]  od3;
   logic [1:0]  os3;

   stream_rr_arbiter #(.NUM_REQ(4), .WIDTH(W)) dut4 (
      .clk(clk), .rst(rst4), .req_valid(v4), .req_ready(r4), .req_data(d4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_src(os4));

   stream_rr_arbiter #(.NUM_REQ(3), .WIDTH(W)) dut3 (
      .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(r3), .req_data(d3),
      .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_src(os3));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // vector table
   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        oready;
      logic [3:0]  exp_ready;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_os;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic o,
                               logic [3:0] er, logic eov, logic [7:0] eod, logic [1:0] eos);
      vec_t x;
      x.rst = r; x.valid = v; x.data = d; x.oready = o;
      x.exp_ready = er; x.exp_ov = eov; x.exp_od = eod; x.exp_os = eos;
      return x;
   endfunction

   // reference model: grant = first valid scanning start, start+1, ... mod 4
   function automatic int pick(logic [3:0] valid, int start);
      for (int k = 0; k < 4; k++) begin
         if (valid[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   int  m_ptr = 0;
   bit  m_ov  = 0;
   logic [7:0] m_od = '0;
   int  m_os  = 0;

   initial begin
      logic [31:0] da;
      logic [31:0] d5;
      int          g;
      bit          slot;
      logic [3:0]  er;

      da = 32'hA3A2A1A0;
      d5 = 32'hA355A1A0;
`ifndef STREAM_ARB_FIXED_PRIO_EN
      vecs.push_back(mk(1, 4'b1111, da, 1, 4'b0000, 0, 8'h00, 0));
      vecs.push_back(mk(0, 4'b1111, da, 1, 4'b0001, 1, 8'hA0, 0));
      vecs.push_back(mk(0, 4'b1111, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1111, da, 1, 4'b0100, 1, 8'hA2, 2));
      vecs.push_back(mk(0, 4'b1111, da, 1, 4'b1000, 1, 8'hA3, 3));
      vecs.push_back(mk(0, 4'b1111, da, 1, 4'b0001, 1, 8'hA0, 0));
      vecs.push_back(mk(0, 4'b0000, da, 1, 4'b0000, 0, 8'hA0, 0));
      vecs.push_back(mk(0, 4'b0100, d5, 0, 4'b0100, 1, 8'h55, 2));
      vecs.push_back(mk(0, 4'b0100, d5, 0, 4'b0000, 1, 8'h55, 2));
      vecs.push_back(mk(0, 4'b0100, d5, 0, 4'b0000, 1, 8'h55, 2));
      vecs.push_back(mk(0, 4'b0100, d5, 0, 4'b0000, 1, 8'h55, 2));
      vecs.push_back(mk(0, 4'b0100, d5, 1, 4'b0100, 1, 8'h55, 2));
      vecs.push_back(mk(0, 4'b0000, d5, 0, 4'b0000, 1, 8'h55, 2));
      vecs.push_back(mk(1, 4'b1111, da, 0, 4'b0000, 0, 8'h00, 0));
      vecs.push_back(mk(0, 4'b1111, da, 0, 4'b0001, 1, 8'hA0, 0));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b1000, 1, 8'hA3, 3));
`else
      vecs.push_back(mk(1, 4'b1111, da, 1, 4'b0000, 0, 8'h00, 0));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1010, da, 1, 4'b0010, 1, 8'hA1, 1));
      vecs.push_back(mk(0, 4'b1000, da, 1, 4'b1000, 1, 8'hA3, 3));
      vecs.push_back(mk(0, 4'b0000, da, 1, 4'b0000, 0, 8'hA3, 3));
`endif

      @(posedge clk); #1;
      // table: drive, check combinational ready, clock, check registered outputs
      foreach (vecs[n]) begin
         rst4 = vecs[n].rst; v4 = vecs[n].valid; d4 = vecs[n].data; or4 = vecs[n].oready;
         #1;
         chk($sformatf("tbl%0d_ready", n), 32'(r4), 32'(vecs[n].exp_ready));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_ovalid", n), 32'(ov4), 32'(vecs[n].exp_ov));
         chk($sformatf("tbl%0d_odata", n), 32'(od4), 32'(vecs[n].exp_od));
         chk($sformatf("tbl%0d_osrc", n), 32'(os4), 32'(vecs[n].exp_os));
      end

      // 3-requester wrap: grant 2, pointer wraps to 0, then 0 beats 1
      d3 = 24'hC2C1C0; or3 = 1'b1; rst3 = 1'b1; v3 = 3'b111;
      #1;
      chk("n3_rst_ready", 32'(r3), 32'(3'b000));
      @(posedge clk); #1;
      chk("n3_rst_ovalid", 32'(ov3), 32'd0);
      rst3 = 1'b0; v3 = 3'b100;
      #1;
      chk("n3_g2_ready", 32'(r3), 32'(3'b100));
      @(posedge clk); #1;
      chk("n3_g2_src", 32'(os3), 32'd2);
      chk("n3_g2_data", 32'(od3), 32'hC2);
      v3 = 3'b011;
      #1;
      chk("n3_wrap_ready", 32'(r3), 32'(3'b001));
      @(posedge clk); #1;
      chk("n3_wrap_src", 32'(os3), 32'd0);
      chk("n3_wrap_data", 32'(od3), 32'hC0);
      v3 = 3'b111;
      #1;
`ifndef STREAM_ARB_FIXED_PRIO_EN
      chk("n3_next_ready", 32'(r3), 32'(3'b010));
      @(posedge clk); #1;
      chk("n3_next_src", 32'(os3), 32'd1);
      #1;
      chk("n3_last_ready", 32'(r3), 32'(3'b100));
      @(posedge clk); #1;
      chk("n3_last_src", 32'(os3), 32'd2);
`else
      chk("n3_next_ready", 32'(r3), 32'(3'b001));
      @(posedge clk); #1;
      chk("n3_next_src", 32'(os3), 32'd0);
`endif
      v3 = '0;

      // random traffic on the 4-requester instance against the model
      rst4 = 1'b1; v4 = '0; #1;
      @(posedge clk); #1;
      m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
      for (int c = 0; c < 1500; c++) begin
         rst4 = ($urandom_range(0, 39) == 0);
         v4   = 4'($urandom_range(0, 15));
         d4   = $urandom;
         or4  = ($urandom_range(0, 3) != 0);
         #1;
         slot = !m_ov || or4;
`ifdef STREAM_ARB_FIXED_PRIO_EN
         g = (rst4 || !slot) ? -1 : pick(v4, 0);
`else
         g = (rst4 || !slot) ? -1 : pick(v4, m_ptr);
`endif
         er = (g >= 0) ? 4'(1 << g) : 4'b0000;
         chk($sformatf("rnd%0d_ready", c), 32'(r4), 32'(er));
         if (rst4) begin
            m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0;
         end else if (slot) begin
            m_ov = (g >= 0);
            if (g >= 0) begin
               m_od  = d4[g*8 +: 8];
               m_os  = g;
               m_ptr = (g + 1) % 4;
            end
         end
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_ovalid", c), 32'(ov4), 32'(m_ov));
         chk($sformatf("rnd%0d_odata", c), 32'(od4), 32'(m_od));
         chk($sformatf("rnd%0d_osrc", c), 32'(os4), 32'(m_os));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
